pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Fetch-stage PC generator for the RV32I pipeline, sitting directly downstream of the branch comparator. It consumes the resolved `branch_taken` result plus jump/branch info from execute, detects mispredictions, redirects the PC and flushes younger stages. With `BTB_EN`, fetch predicts taken branches from a small branch target buffer; without it, fetch always predicts not-taken.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `BTB_IDX_W`, 4, log2 of BTB entries (16); used only with `BTB_EN`
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `stall` input 1: hold `pc_f` (hazard unit)
- `ex_valid` input 1: execute holds a valid instruction
- `ex_is_branch` input 1: conditional branch in execute
- `ex_is_jump` input 1: JAL/JALR in execute
- `ex_branch_taken` input 1: comparator result
- `ex_pc` input 32: PC of the execute instruction
- `ex_target` input 32: computed branch/jump target
- `ex_pred_taken` input 1: prediction carried down with the instruction
- `ex_pred_target` input 32: predicted target carried down with the instruction
- `pc_f` output 32: current fetch PC
- `pc_valid` output 1: `pc_f` is a real fetch
- `pred_taken_f` output 1: prediction for `pc_f`
- `pred_target_f` output 32: predicted next PC for `pc_f`
- `flush` output 1: kill IF/ID and ID/EX this cycle
- `mispredict_cnt` output 16: saturating mispredict count

## Operation
- FSM states: BOOT, RUN. `rst` forces BOOT. BOOT -> RUN unconditionally on the next edge. In BOOT, `pc_valid=0`; in RUN, `pc_valid=1`.
- Resolution, combinational: `actual = ex_is_jump | (ex_is_branch & ex_branch_taken)`.
- `mispredict = ex_valid & (ex_is_branch|ex_is_jump) & ((actual != ex_pred_taken) | (actual & ex_pred_taken & ex_target != ex_pred_target))`.
- `correct_pc = actual ? ex_target : ex_pc + 4`.
- `flush = mispredict & ~rst`, combinational.
- Next-PC priority: `rst` -> `RESET_PC`; mispredict -> `correct_pc` (overrides `stall`); `stall` -> hold; in BOOT -> hold; otherwise -> `pred_target_f`.
- `pred_target_f = pred_taken_f ? btb_target : pc_f + 4`. All PC arithmetic is 32-bit modulo. 0xFFFF_FFFC + 4 wraps to 0.
- `mispredict_cnt` increments on each mispredict and saturates at 0xFFFF.
- Reset values: `pc_f=RESET_PC`, `pc_valid=0`, `pred_taken_f=0`, `pred_target_f=RESET_PC+4`, `flush=0`, `mispredict_cnt=0`, all BTB valid bits 0.

## Timing
- Redirect latency: mispredict sampled in cycle N, so `pc_f=correct_pc` in N+1. Two younger instructions are flushed at the N edge.
- Prediction is combinational from `pc_f`. Taken-predicted fetch proceeds with zero bubble.
- The BTB update is written at the same edge as the resolution. A lookup in the same cycle sees the old contents.
- `stall` and mispredict together: the redirect wins, and `stall` is ignored for that edge.
- `rst` mid-operation: the next edge restores all reset values regardless of other inputs, and `flush` is 0 while `rst`=1.

## Configuration
- `BTB_EN` defined:
  - The BTB is direct-mapped with 2^`BTB_IDX_W` entries. Each entry holds {valid, tag=pc[31:BTB_IDX_W+2], target, 2-bit counter}. Index is pc[BTB_IDX_W+1:2].
  - Lookup hit with counter[1]=1 gives `pred_taken_f=1`.
  - Update occurs on `ex_valid & (ex_is_branch|ex_is_jump)`:
    - Hit: counter inc (sat 3) if `actual`, else dec (sat 0). The target is rewritten with `ex_target` if `actual`.
    - Miss with `actual=1`: allocate or replace, with counter=2'b10.
    - Miss with `actual=0`: no change.
- `BTB_EN` undefined: no BTB storage. `pred_taken_f` is constantly 0 and `pred_target_f=pc_f+4`.

## Test plan
- Reset, then release: `pc_f` reads 0x0 for 2 cycles (BOOT, then first RUN fetch), `pc_valid` rises after 1 cycle, then `pc_f` steps 0x4, 0x8.
- Not-taken branch: `ex_pc`=0x10, `ex_is_branch=1`, `ex_branch_taken=0`, `ex_pred_taken=0` -> `flush=0`, no redirect, `mispredict_cnt` unchanged.
- Taken branch mispredict: `ex_pc`=0x10, `ex_target`=0x40, taken, `pred=0` -> `flush=1` same cycle, `pc_f`=0x40 next cycle, `mispredict_cnt`=1. Repeat with `stall=1`: same result.
- JALR wrong target: `pred_taken=1`, `ex_pred_target`=0x80, `ex_target`=0x90 -> `flush=1`, `pc_f`=0x90.
- `BTB_EN`: resolve a taken branch at 0x20 with target 0x100. Refetch 0x20: `pred_taken_f=1`, `pc_f`=0x100 next cycle. Two not-taken resolutions then return the prediction to not-taken.
- Counter saturation: force 0x10000 mispredicts -> `mispredict_cnt` holds 0xFFFF. Assert `rst` mid-stream -> all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC generator: resolves branches from execute, redirects on mispredict.
// Define BTB_EN to enable the direct-mapped branch target buffer predictor.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [31:0] pc_f,
  output logic        pc_valid,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  output logic        flush,
  output logic [15:0] mispredict_cnt
);

  typedef enum logic {BOOT, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;

  logic        actual;
  logic        resolve;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] pc_plus4;
  logic [31:0] btb_target;

  always_comb begin
    actual     = ex_is_jump | (ex_is_branch & ex_branch_taken);
    resolve    = ex_valid & (ex_is_branch | ex_is_jump);
    mispredict = resolve & ((actual != ex_pred_taken) |
                            (actual & ex_pred_taken & (ex_target != ex_pred_target)));
    correct_pc = actual ? ex_target : ex_pc + 32'd4;
    flush      = mispredict & ~rst;
  end

  assign pc_plus4      = pc_q + 32'd4;
  assign pc_f          = pc_q;
  assign pred_target_f = pred_taken_f ? btb_target : pc_plus4;
  assign mispredict_cnt = cnt_q;

`ifdef BTB_EN
  localparam int unsigned ENTRIES = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W   = 30 - BTB_IDX_W;

  logic [ENTRIES-1:0] v_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [BTB_IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0]     f_tag, e_tag;
  logic                 f_hit, e_hit;

  always_comb begin
    f_idx        = pc_q[BTB_IDX_W+1:2];
    f_tag        = pc_q[31:BTB_IDX_W+2];
    e_idx        = ex_pc[BTB_IDX_W+1:2];
    e_tag        = ex_pc[31:BTB_IDX_W+2];
    f_hit        = v_q[f_idx] && (tag_q[f_idx] == f_tag);
    e_hit        = v_q[e_idx] && (tag_q[e_idx] == e_tag);
    pred_taken_f = f_hit & ctr_q[f_idx][1];
    btb_target   = tgt_q[f_idx];
  end

  // Written at the resolving edge, so a same-cycle lookup sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else if (resolve) begin
      if (e_hit) begin
        if (actual) begin
          tgt_q[e_idx] <= ex_target;
          if (ctr_q[e_idx] != 2'b11) ctr_q[e_idx] <= ctr_q[e_idx] + 2'd1;
        end else if (ctr_q[e_idx] != 2'b00) begin
          ctr_q[e_idx] <= ctr_q[e_idx] - 2'd1;
        end
      end else if (actual) begin
        v_q[e_idx]   <= 1'b1;
        tag_q[e_idx] <= e_tag;
        tgt_q[e_idx] <= ex_target;
        ctr_q[e_idx] <= 2'b10;
      end
    end
  end
`else
  logic unused_btb_cfg;
  assign unused_btb_cfg = |BTB_IDX_W;
  assign pred_taken_f   = 1'b0;
  assign btb_target     = pc_plus4;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_valid = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN:  pc_valid = 1'b1;
      default: state_d = BOOT;
    endcase
    if (mispredict)                   pc_d = correct_pc;
    else if (!stall && state_q == RUN) pc_d = pred_target_f;
    if (mispredict && cnt_q != '1)    cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected outputs per cycle, monitor compares.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, ex_valid, ex_is_branch, ex_is_jump, ex_branch_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_pred_taken;
  logic [31:0] pc_f, pred_target_f;
  logic        pc_valid, pred_taken_f, flush;
  logic [15:0] mispredict_cnt;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .BTB_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_branch_taken(ex_branch_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc_f(pc_f), .pc_valid(pc_valid), .pred_taken_f(pred_taken_f),
    .pred_target_f(pred_target_f), .flush(flush), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] pc;
    logic        v;
    logic        fl;
    logic [15:0] cnt;
    logic        pt;
    logic [31:0] ptg;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: stale at cycle %0d expected cycle %0d", e.name, cyc, e.cyc);
        end else begin
          chk({e.name, ".pc_f"}, pc_f, e.pc);
          chk({e.name, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, e.v});
          chk({e.name, ".flush"}, {31'd0, flush}, {31'd0, e.fl});
          chk({e.name, ".cnt"}, {16'd0, mispredict_cnt}, {16'd0, e.cnt});
          chk({e.name, ".pred_taken"}, {31'd0, pred_taken_f}, {31'd0, e.pt});
          chk({e.name, ".pred_target"}, pred_target_f, e.ptg);
        end
      end
    end
  end

  task automatic push(input string n, input logic [31:0] pc, input logic v, input logic fl,
                      input logic [15:0] cnt, input logic pt, input logic [31:0] ptg);
    exp_t e;
    e.cyc = cyc; e.name = n; e.pc = pc; e.v = v; e.fl = fl;
    e.cnt = cnt; e.pt = pt; e.ptg = ptg;
    sbq.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 0; ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_branch_taken = 0;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic ex(input logic br, input logic jmp, input logic tk, input logic [31:0] pc,
                    input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
    ex_valid = 1; ex_is_branch = br; ex_is_jump = jmp; ex_branch_taken = tk;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  initial begin : stim
    rst = 1; clr();
    nxt(); push("rst", 32'h0, 0, 0, 16'd0, 0, 32'h4); rst = 0;
    nxt(); push("boot_exit", 32'h0, 1, 0, 16'd0, 0, 32'h4);
    nxt(); push("seq4", 32'h4, 1, 0, 16'd0, 0, 32'h8);
    nxt(); push("seq8", 32'h8, 1, 0, 16'd0, 0, 32'hC);
    nxt(); ex(1, 0, 0, 32'h10, 32'h40, 0, 32'h0); push("br_nt", 32'hC, 1, 0, 16'd0, 0, 32'h10);
    nxt(); clr(); push("after_nt", 32'h10, 1, 0, 16'd0, 0, 32'h14);
    nxt(); ex(1, 0, 1, 32'h10, 32'h40, 0, 32'h0); push("br_tk", 32'h14, 1, 1, 16'd0, 0, 32'h18);
    nxt(); clr(); push("redir", 32'h40, 1, 0, 16'd1, 0, 32'h44);
    nxt(); ex(1, 0, 1, 32'h10, 32'h40, 0, 32'h0); stall = 1;
    push("stall_mp", 32'h44, 1, 1, 16'd1, 0, 32'h48);
    nxt(); clr(); push("redir_st", 32'h40, 1, 0, 16'd2, 0, 32'h44);
    nxt(); stall = 1; push("stall", 32'h44, 1, 0, 16'd2, 0, 32'h48);
    nxt(); stall = 0; push("held", 32'h44, 1, 0, 16'd2, 0, 32'h48);
    nxt(); ex(0, 1, 1, 32'h60, 32'h90, 1, 32'h80); push("jalr_bad", 32'h48, 1, 1, 16'd2, 0, 32'h4C);
    nxt(); ex(0, 1, 1, 32'h60, 32'h90, 1, 32'h90); push("jalr_redir", 32'h90, 1, 0, 16'd3, 0, 32'h94);
    nxt(); ex(1, 0, 1, 32'h200, 32'hFFFF_FFFC, 0, 32'h0);
    push("wrap_mp", 32'h94, 1, 1, 16'd3, 0, 32'h98);
    nxt(); clr(); push("wrap_top", 32'hFFFF_FFFC, 1, 0, 16'd4, 0, 32'h0);
    nxt(); ex(1, 0, 1, 32'h10, 32'h40, 0, 32'h0); ex_valid = 0;
    push("inval", 32'h0, 1, 0, 16'd4, 0, 32'h4);
    nxt(); clr(); push("wrap_next", 32'h4, 1, 0, 16'd4, 0, 32'h8);
`ifdef BTB_EN
    nxt(); ex(1, 0, 1, 32'h20, 32'h100, 0, 32'h0); push("btb_alloc", 32'h8, 1, 1, 16'd4, 0, 32'hC);
    nxt(); ex(0, 1, 1, 32'h300, 32'h20, 0, 32'h0); push("btb_go", 32'h100, 1, 1, 16'd5, 0, 32'h104);
    nxt(); clr(); push("btb_hit", 32'h20, 1, 0, 16'd6, 1, 32'h100);
    nxt(); ex(1, 0, 0, 32'h20, 32'h100, 1, 32'h100); push("btb_zb", 32'h100, 1, 1, 16'd6, 0, 32'h104);
    nxt(); ex(1, 0, 0, 32'h20, 32'h100, 0, 32'h0); push("btb_nt2", 32'h24, 1, 0, 16'd7, 0, 32'h28);
    nxt(); ex(0, 1, 1, 32'h400, 32'h20, 0, 32'h0); push("btb_back", 32'h28, 1, 1, 16'd7, 0, 32'h2C);
    nxt(); clr(); push("btb_nt", 32'h20, 1, 0, 16'd8, 0, 32'h24);
    nxt(); push("btb_nt_next", 32'h24, 1, 0, 16'd8, 0, 32'h28);
`endif
    // Continuous mispredicts: 65540 increments from a small start must saturate.
    nxt(); ex(0, 1, 1, 32'h500, 32'h600, 0, 32'h0);
    repeat (65540) nxt();
    push("sat", 32'h600, 1, 1, 16'hFFFF, 0, 32'h604);
    nxt(); push("sat_hold", 32'h600, 1, 1, 16'hFFFF, 0, 32'h604);
    nxt(); rst = 1; push("rst_flush", 32'h600, 1, 0, 16'hFFFF, 0, 32'h604);
    nxt(); push("rst_vals", 32'h0, 0, 0, 16'd0, 0, 32'h4); rst = 0; clr();
    nxt(); push("reboot", 32'h0, 1, 0, 16'd0, 0, 32'h4);
    nxt(); push("rerun", 32'h4, 1, 0, 16'd0, 0, 32'h8);
    repeat (3) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
